// File: rtl/cpu_pkg.sv
// Shared definitions for the ECE350 multicycle core: opcodes, ALU ops,
// instruction field positions and the instruction-cycle state type.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_LINK   = 5'd31;

  localparam int OPC_LSB   = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;
  localparam int IMM_W     = 17;
  localparam int TGT_W     = 27;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add/sub/and/or/sll/sra plus signed less-than,
// inequality and signed-overflow flags for the branch and status logic.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        alu_op,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              lt,
  output logic              neq,
  output logic              ovf
);

  logic signed [DATA_W-1:0] sa, sb, sum, diff;

  assign sa   = a;
  assign sb   = b;
  assign sum  = sa + sb;
  assign diff = sa - sb;
  assign lt   = sa < sb;
  assign neq  = sa != sb;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        result = sum;
        ovf    = (sa[DATA_W-1] == sb[DATA_W-1]) && (sum[DATA_W-1] != sa[DATA_W-1]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (sa[DATA_W-1] != sb[DATA_W-1]) && (diff[DATA_W-1] != sa[DATA_W-1]);
      end
      ALU_AND: result = sa & sb;
      ALU_OR:  result = sa | sb;
      ALU_SLL: result = sa << shamt;
      ALU_SRA: result = sa >>> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ece350_cpu_core.sv
// Multicycle ECE350 core, fixed FETCH/DECODE/EXEC/MEM/WB cycle (CPI 5).
// Define CPU_OVF_STATUS_EN to redirect add/addi/sub overflow to an r30 status write.
module ece350_cpu_core
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);

  localparam int DATA_W = XLEN;
`ifdef CPU_OVF_STATUS_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] n);
    return {{(DATA_W-IMM_W){n[IMM_W-1]}}, n};
  endfunction

  state_e state, state_nx;
  logic [DATA_W-1:0] pc, pc_inc, ir_p0;
  logic [4:0]        opc, rd, rs, rt, shamt, aop;
  logic [DATA_W-1:0] imm_n, tgt;

  logic [4:0]        alu_op;
  logic [DATA_W-1:0] alu_b, alu_res;
  logic              alu_lt, alu_neq, alu_ovf;

  logic              wr_req, is_sw, is_lw;
  logic [4:0]        wr_idx;
  logic [DATA_W-1:0] wr_val, npc;

  logic [DATA_W-1:0] res_p1, st_data_p1, npc_p1;
  logic [4:0]        wr_reg_p1;
  logic              vld_p1, sw_p1, lw_p1;

  assign opc    = ir_p0[OPC_LSB +: 5];
  assign rd     = ir_p0[RD_LSB +: 5];
  assign rs     = ir_p0[RS_LSB +: 5];
  assign rt     = ir_p0[RT_LSB +: 5];
  assign shamt  = ir_p0[SHAMT_LSB +: 5];
  assign aop    = ir_p0[ALUOP_LSB +: 5];
  assign imm_n  = sext_imm(ir_p0[IMM_W-1:0]);
  assign tgt    = {{(DATA_W-TGT_W){1'b0}}, ir_p0[TGT_W-1:0]};
  assign pc_inc = pc + 32'd1;

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC:   state_nx = S_MEM;
      S_MEM:    state_nx = S_WB;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Read indices depend only on IR, kept apart from the logic consuming read data.
  always_comb begin
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;
    case (opc)
      OP_RTYPE:        begin ctrl_readRegA = rs; ctrl_readRegB = rt; end
      OP_ADDI, OP_LW:  ctrl_readRegA = rs;
      OP_SW:           begin ctrl_readRegA = rs; ctrl_readRegB = rd; end
      OP_BNE, OP_BLT:  begin ctrl_readRegA = rd; ctrl_readRegB = rs; end
      OP_JR:           ctrl_readRegA = rd;
      OP_BEX:          ctrl_readRegA = REG_STATUS;
      default:         ;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = data_readRegB;
    wr_req = 1'b0;
    wr_idx = rd;
    wr_val = alu_res;
    is_sw  = 1'b0;
    is_lw  = 1'b0;
    npc    = pc_inc;
    case (opc)
      OP_RTYPE: begin
        alu_op = aop;
        wr_req = (aop <= ALU_SRA);
      end
      OP_ADDI: begin alu_b = imm_n; wr_req = 1'b1; end
      OP_LW:   begin alu_b = imm_n; wr_req = 1'b1; is_lw = 1'b1; end
      OP_SW:   begin alu_b = imm_n; is_sw = 1'b1; end
      OP_BNE: begin
        alu_op = ALU_SUB;
        if (alu_neq) npc = pc_inc + imm_n;
      end
      OP_BLT: begin
        alu_op = ALU_SUB;
        if (alu_lt) npc = pc_inc + imm_n;
      end
      OP_J:    npc = tgt;
      OP_JAL:  begin npc = tgt; wr_req = 1'b1; wr_idx = REG_LINK; wr_val = pc_inc; end
      OP_JR:   npc = data_readRegA;
      OP_SETX: begin wr_req = 1'b1; wr_idx = REG_STATUS; wr_val = tgt; end
      OP_BEX:  if (data_readRegA != '0) npc = tgt;
      default: ;
    endcase
    // Overflow status code: 1 = add, 2 = addi, 3 = sub; the original rd is dropped.
    if (OVF_EN && alu_ovf &&
        ((opc == OP_ADDI) || ((opc == OP_RTYPE) && ((aop == ALU_ADD) || (aop == ALU_SUB))))) begin
      wr_idx = REG_STATUS;
      wr_val = (opc == OP_ADDI) ? 32'd2 : ((aop == ALU_ADD) ? 32'd1 : 32'd3);
    end
    if (wr_idx == 5'd0) wr_req = 1'b0;
  end

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (data_readRegA),
    .b      (alu_b),
    .alu_op (alu_op),
    .shamt  (shamt),
    .result (alu_res),
    .lt     (alu_lt),
    .neq    (alu_neq),
    .ovf    (alu_ovf)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir_p0  <= '0;
      vld_p1 <= 1'b0;
      sw_p1  <= 1'b0;
      lw_p1  <= 1'b0;
    end else begin
      state <= state_nx;
      // DECODE -> EXEC: capture the registered ROM word
      if (state == S_DECODE) ir_p0 <= q_imem;
      // EXEC -> MEM/WB: control for the memory and write-back slots
      if (state == S_EXEC) begin
        vld_p1 <= wr_req;
        sw_p1  <= is_sw;
        lw_p1  <= is_lw;
      end
      // WB -> FETCH: commit the next PC
      if (state == S_WB) pc <= npc_p1;
    end
  end

  // EXEC -> MEM/WB: datapath latches
  always_ff @(posedge clock) begin
    if (state == S_EXEC) begin
      res_p1     <= wr_val;
      st_data_p1 <= data_readRegB;
      npc_p1     <= npc;
      wr_reg_p1  <= wr_idx;
    end
  end

  assign address_imem     = pc;
  assign wren             = !reset && (state == S_MEM) && sw_p1;
  assign address_dmem     = res_p1;
  assign data             = st_data_p1;
  assign ctrl_writeEnable = !reset && (state == S_WB) && vld_p1;
  assign ctrl_writeReg    = wr_reg_p1;
  assign data_writeReg    = lw_p1 ? q_dmem : res_p1;

endmodule

// File: tb/tb_ece350_cpu_core.sv
// Bench for ece350_cpu_core: ROM/RAM/register file around the core and an
// instruction-level ISA model checked against the core every cycle.
module tb_ece350_cpu_core;

`ifdef CPU_OVF_STATUS_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clr   = 1'b1;
  logic [31:0] address_imem, q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem;

  logic [31:0] rom [0:127];
  logic [31:0] ram [0:127];
  logic [31:0] rf  [0:31];

  logic [31:0] mregs [0:31];
  logic [31:0] mmem  [0:127];
  logic [31:0] mpc;
  logic        exp_we, exp_st;
  logic [4:0]  exp_wreg;
  logic [31:0] exp_wval, exp_addr, exp_data, exp_npc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ece350_cpu_core dut (
    .clock            (clock),
    .reset            (reset),
    .address_imem     (address_imem),
    .q_imem           (q_imem),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .wren             (wren),
    .address_dmem     (address_dmem),
    .data             (data),
    .q_dmem           (q_dmem)
  );

  always @(posedge clock) q_imem <= rom[address_imem[6:0]];

  always @(posedge clock) begin
    if (clr) for (int i = 0; i < 128; i++) ram[i] <= '0;
    else if (wren) ram[address_dmem[6:0]] <= data;
    q_dmem <= ram[address_dmem[6:0]];
  end

  always @(posedge clock) begin
    if (clr) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
  end

  assign data_readRegA = rf[ctrl_readRegA];
  assign data_readRegB = rf[ctrl_readRegB];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt, sh, aop);
    return {5'b00000, rd, rs, rt, sh, aop, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input int n);
    logic [31:0] nv;
    nv = n;
    return {op, rd, rs, nv[16:0]};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] op, input int t);
    logic [31:0] tv;
    tv = t;
    return {op, tv[26:0]};
  endfunction

  // ISA-level execution of one instruction against the model state.
  task automatic model_exec(input logic [31:0] ins);
    logic [4:0]  op, rd, rs, rt, sh, aop;
    logic [31:0] a, b, n, t, r, code;
    logic        ovf;
    op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17];
    rt = ins[16:12]; sh = ins[11:7];  aop = ins[6:2];
    n = {{15{ins[16]}}, ins[16:0]};
    t = {5'd0, ins[26:0]};
    exp_we = 1'b0; exp_st = 1'b0; exp_wreg = rd; exp_wval = '0;
    exp_addr = '0; exp_data = '0; exp_npc = mpc + 32'd1;
    ovf = 1'b0; code = '0; r = '0;
    a = mregs[rs];
    case (op)
      5'b00000: begin
        b = mregs[rt];
        exp_we = 1'b1;
        case (aop)
          5'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); code = 32'd1; end
          5'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); code = 32'd3; end
          5'd2: r = a & b;
          5'd3: r = a | b;
          5'd4: r = a << sh;
          5'd5: r = $signed(a) >>> sh;
          default: exp_we = 1'b0;
        endcase
        exp_wval = r;
      end
      5'b00101: begin
        r = a + n; ovf = (a[31] == n[31]) && (r[31] != a[31]); code = 32'd2;
        exp_we = 1'b1; exp_wval = r;
      end
      5'b00111: begin exp_st = 1'b1; exp_addr = a + n; exp_data = mregs[rd]; end
      5'b01000: begin r = a + n; exp_we = 1'b1; exp_wval = mmem[r[6:0]]; end
      5'b00001: exp_npc = t;
      5'b00011: begin exp_npc = t; exp_we = 1'b1; exp_wreg = 5'd31; exp_wval = mpc + 32'd1; end
      5'b00100: exp_npc = mregs[rd];
      5'b00010: if (mregs[rd] != mregs[rs]) exp_npc = mpc + 32'd1 + n;
      5'b00110: if ($signed(mregs[rd]) < $signed(mregs[rs])) exp_npc = mpc + 32'd1 + n;
      5'b10101: begin exp_we = 1'b1; exp_wreg = 5'd30; exp_wval = t; end
      5'b10110: if (mregs[30] != 32'd0) exp_npc = t;
      default: ;
    endcase
    if (OVF_EN && ovf) begin exp_wreg = 5'd30; exp_wval = code; end
    if (exp_wreg == 5'd0) exp_we = 1'b0;
    if (exp_we) mregs[exp_wreg] = exp_wval;
    if (exp_st) mmem[exp_addr[6:0]] = exp_data;
  endtask

  // Called at a negedge that starts a FETCH cycle; checks all five cycles of each instruction.
  task automatic run_instr(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      model_exec(rom[mpc[6:0]]);
      for (int ph = 0; ph < 5; ph++) begin
        #1;
        chk("imem_addr", address_imem, mpc);
        if (ph == 3) begin
          chk("wren", 32'(wren), 32'(exp_st));
          if (exp_st) begin
            chk("dmem_addr", address_dmem, exp_addr);
            chk("dmem_data", data, exp_data);
          end
        end else chk("wren_idle", 32'(wren), 32'd0);
        if (ph == 4) begin
          chk("reg_we", 32'(ctrl_writeEnable), 32'(exp_we));
          if (exp_we) begin
            chk("reg_idx", 32'(ctrl_writeReg), 32'(exp_wreg));
            chk("reg_data", data_writeReg, exp_wval);
          end
        end else chk("reg_we_idle", 32'(ctrl_writeEnable), 32'd0);
        @(negedge clock);
      end
      mpc = exp_npc;
    end
  endtask

  task automatic do_reset(input bit clear);
    reset = 1'b1;
    clr   = clear;
    #1;
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
    repeat (3) begin
      @(posedge clock); #1;
      chk("rst_wren", 32'(wren), 32'd0);
      chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    clr   = 1'b0;
    if (clear) begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      for (int i = 0; i < 128; i++) mmem[i] = '0;
    end
    mpc = 32'd0;
    chk("rst_pc", address_imem, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0]  = enc_i(5'b00101, 1, 0, 5);        // addi r1,r0,5
    rom[1]  = enc_i(5'b00101, 2, 1, -7);       // addi r2,r1,-7
    rom[2]  = enc_i(5'b00111, 1, 0, 3);        // sw r1,3(r0)
    rom[3]  = enc_i(5'b01000, 3, 0, 3);        // lw r3,3(r0)
    rom[4]  = enc_j(5'b00011, 30);             // jal 30
    rom[30] = enc_i(5'b00100, 31, 0, 0);       // jr r31
    rom[5]  = enc_r(4, 1, 2, 0, 0);            // add r4,r1,r2
    rom[6]  = enc_r(5, 1, 2, 0, 1);            // sub r5,r1,r2
    rom[7]  = enc_r(6, 1, 2, 0, 2);            // and r6,r1,r2
    rom[8]  = enc_j(5'b00001, 10);             // j 10
    rom[9]  = enc_i(5'b00101, 2, 1, 0);        // addi r2,r1,0
    rom[10] = enc_i(5'b00010, 1, 2, -2);       // bne r1,r2,-2
    rom[11] = enc_r(8, 1, 0, 3, 4);            // sll r8,r1,3
    rom[12] = enc_i(5'b00101, 10, 0, -8);      // addi r10,r0,-8
    rom[13] = enc_r(9, 10, 0, 1, 5);           // sra r9,r10,1
    rom[14] = enc_i(5'b00110, 10, 0, 2);       // blt r10,r0,+2
    rom[15] = enc_i(5'b00101, 12, 0, 99);
    rom[16] = enc_i(5'b00101, 12, 0, 99);
    rom[17] = enc_i(5'b00110, 0, 10, 5);       // blt r0,r10,+5
    rom[18] = enc_r(7, 1, 10, 0, 3);           // or r7,r1,r10
    rom[19] = enc_j(5'b10101, 7);              // setx 7
    rom[20] = enc_j(5'b10110, 40);             // bex 40
    rom[40] = enc_r(0, 1, 1, 0, 0);            // add r0,r1,r1
    rom[41] = 32'hF800_0000;                   // unknown opcode
    rom[42] = enc_r(20, 1, 1, 0, 6);           // mul: unsupported ALUop
    rom[43] = enc_i(5'b00101, 16, 0, 1);       // addi r16,r0,1
    rom[44] = enc_r(15, 16, 0, 30, 4);         // sll r15,r16,30
    rom[45] = enc_r(14, 15, 16, 0, 1);         // sub r14,r15,r16
    rom[46] = enc_r(14, 14, 0, 1, 4);          // sll r14,r14,1
    rom[47] = enc_r(14, 14, 16, 0, 3);         // or r14,r14,r16
    rom[48] = enc_r(17, 14, 16, 0, 0);         // add r17,r14,r16 (overflows)
    rom[49] = enc_i(5'b00101, 19, 14, 1);      // addi r19,r14,1 (overflows)
    rom[50] = enc_j(5'b10110, 60);             // bex 60
    rom[60] = enc_j(5'b10101, 0);              // setx 0
    rom[61] = enc_j(5'b10110, 5);              // bex 5 (not taken)

    do_reset(1'b1);
    run_instr(32);
    chk("bex_target", address_imem, 32'd60);
    chk("model_pc", mpc, 32'd60);
    chk("r1", rf[1], 32'd5);
    chk("r3_lw", rf[3], 32'd5);
    chk("r31_link", rf[31], 32'd5);
    chk("r4_add", rf[4], 32'd3);
    chk("r5_sub", rf[5], 32'd7);
    chk("r6_and", rf[6], 32'd4);
    chk("r8_sll", rf[8], 32'd40);
    chk("r9_sra", rf[9], 32'hFFFF_FFFC);
    chk("r7_or", rf[7], 32'hFFFF_FFFD);
    chk("r12_skip", rf[12], 32'd0);
    chk("r20_mul", rf[20], 32'd0);
    chk("r14", rf[14], 32'h7FFF_FFFF);
    chk("ram3", ram[3], 32'd5);
    chk("r17_ovf", rf[17], OVF_EN ? 32'd0 : 32'h8000_0000);
    chk("r19_ovf", rf[19], OVF_EN ? 32'd0 : 32'h8000_0000);
    chk("r30_status", rf[30], OVF_EN ? 32'd2 : 32'd7);
    run_instr(2);
    chk("bex_not_taken", address_imem, 32'd62);

    do_reset(1'b1);
    run_instr(2);
    chk("r2_neg", rf[2], 32'hFFFF_FFFE);
    @(negedge clock);
    @(negedge clock);
    do_reset(1'b0);
    chk("abandon_sw", ram[3], 32'd0);
    run_instr(4);
    chk("ram3_after", ram[3], 32'd5);
    chk("r3_after", rf[3], 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
